// File: rtl/clock_pkg.sv
// Shared types, digit limits and the HH:MM increment helper for the time keeper.
//
// bcd_time_t : packed HH:MM:SS in BCD, laid out exactly as disp_time
//              {ht[1:0], hu[3:0], mt[2:0], mu[3:0], st[2:0], su[3:0]}
// bcd_hm_t   : packed HH:MM in BCD, used for the alarm register and for
//              the hour/minute half of the running time
// bcd_inc_hm : hours +1 (mod 24) and/or minutes +1 (mod 60), independently,
//              with no carry from minutes into hours
package clock_pkg;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
  } bcd_hm_t;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
  } bcd_time_t;

  localparam logic [1:0] MAX_HT        = 2'd2;
  localparam logic [3:0] MAX_HU_AT_HT2 = 4'd3;
  localparam logic [2:0] MAX_TENS      = 3'd5;
  localparam logic [3:0] MAX_UNITS     = 4'd9;

  // The two increments are applied independently so that both edit pulses
  // landing in the same cycle take effect together. The running clock reuses
  // this for its minute/hour rollover by driving inc_h from "minutes at 59".
  function automatic bcd_hm_t bcd_inc_hm(input bcd_hm_t v,
                                         input logic    inc_h,
                                         input logic    inc_m);
    bcd_hm_t r;
    r = v;
    if (inc_m) begin
      if (v.mu == MAX_UNITS) begin
        r.mu = 4'd0;
        if (v.mt == MAX_TENS) begin
          r.mt = 3'd0;
        end else begin
          r.mt = v.mt + 3'd1;
        end
      end else begin
        r.mu = v.mu + 4'd1;
      end
    end
    if (inc_h) begin
      if ((v.ht == MAX_HT) && (v.hu == MAX_HU_AT_HT2)) begin
        r.ht = 2'd0;
        r.hu = 4'd0;
      end else if (v.hu == MAX_UNITS) begin
        r.hu = 4'd0;
        r.ht = v.ht + 2'd1;
      end else begin
        r.hu = v.hu + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that produces a single-cycle tick once every CLK_FREQ clocks.
//
// clk    in   system clock
// reset  in   asynchronous, active-high reset
// clear  in   synchronous clear: holds the count at 0 and suppresses tick
// tick   out  high for the one cycle in which the count sits at CLK_FREQ-1
module tick_gen #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] count;

  // Free-running modulo-CLK_FREQ counter; clear parks it at 0 so the first
  // second after an edit is a full second long.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Gating with clear keeps a stale terminal count from leaking a tick in the
  // cycle where clear is first raised.
  assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/time_keeper.sv
// 24 h BCD clock with an editable HH:MM alarm and a time-limited alarm output.
//
// clk        in   system clock
// reset      in   asynchronous, active-high reset
// set_time   in   level: edit current time (wins over set_alarm)
// set_alarm  in   level: edit alarm time
// alarm_en   in   level: alarm armed
// inc_hour   in   pulse: hours +1 in edit mode
// inc_min    in   pulse: minutes +1 in edit mode
// alarm_off  in   pulse: silence a ringing alarm
// disp_time  out  packed BCD HH:MM:SS (alarm HH:MM:00 while editing the alarm)
// alarm      out  registered alarm trigger
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_FREQ         = 100_000_000,
  parameter int ALARM_DURATION_S = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_time,
  input  logic        set_alarm,
  input  logic        alarm_en,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        alarm_off,
  output logic [19:0] disp_time,
  output logic        alarm
);

  localparam int               DUR_W    = $clog2(ALARM_DURATION_S + 1);
  localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(ALARM_DURATION_S);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RINGING = 1'b1;

  logic             tick;
  bcd_time_t        cur_time;
  bcd_time_t        next_time;
  bcd_time_t        alarm_as_time;
  bcd_hm_t          cur_hm;
  bcd_hm_t          edited_hm;
  bcd_hm_t          rolled_hm;
  bcd_hm_t          alarm_hm;
  logic             min_at_59;
  logic             trigger;
  logic             stop_alarm;
  logic [0:0]       state;
  logic [DUR_W-1:0] dur_cnt;

  tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(set_time),
    .tick (tick)
  );

  assign cur_hm        = {cur_time.ht, cur_time.hu, cur_time.mt, cur_time.mu};
  assign alarm_as_time = {alarm_hm, 3'd0, 4'd0};

  // Minute rollover from the seconds chain carries into hours only when the
  // minutes are already at 59, which is exactly the edit helper with inc_h
  // driven by that condition.
  assign min_at_59 = (cur_time.mt == MAX_TENS) && (cur_time.mu == MAX_UNITS);
  assign rolled_hm = bcd_inc_hm(cur_hm, min_at_59, 1'b1);
  assign edited_hm = bcd_inc_hm(cur_hm, inc_hour, inc_min);

  // One-second advance of the running time, used only on a tick.
  always_comb begin
    next_time = cur_time;
    if (cur_time.su == MAX_UNITS) begin
      next_time.su = 4'd0;
      if (cur_time.st == MAX_TENS) begin
        next_time.st = 3'd0;
        next_time.ht = rolled_hm.ht;
        next_time.hu = rolled_hm.hu;
        next_time.mt = rolled_hm.mt;
        next_time.mu = rolled_hm.mu;
      end else begin
        next_time.st = cur_time.st + 3'd1;
      end
    end else begin
      next_time.su = cur_time.su + 4'd1;
    end
  end

  // Current time: editing zeroes the seconds and applies the pulses; otherwise
  // the time only moves on a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_time <= '0;
    end else if (set_time) begin
      cur_time <= {edited_hm, 3'd0, 4'd0};
    end else if (tick) begin
      cur_time <= next_time;
    end
  end

  // Alarm register is editable only when the time itself is not being edited.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_hm <= '0;
    end else if (set_alarm && !set_time) begin
      alarm_hm <= bcd_inc_hm(alarm_hm, inc_hour, inc_min);
    end
  end

  // Only a tick landing on HH:MM:00 can fire, so editing the alarm onto the
  // current minute never rings and a minute cannot retrigger itself.
  assign trigger    = tick && !set_time && !set_alarm && alarm_en &&
                      (next_time == alarm_as_time);
  assign stop_alarm = alarm_off || !alarm_en || set_time;

  // Alarm FSM. Silencing outranks a simultaneous trigger; a trigger while
  // already ringing reloads the duration. The counter reaching zero ends the
  // ring on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dur_cnt <= '0;
    end else if (stop_alarm) begin
      state   <= IDLE;
      dur_cnt <= '0;
    end else if (trigger) begin
      state   <= RINGING;
      dur_cnt <= DUR_LOAD;
    end else if (state == RINGING) begin
      if (dur_cnt == '0) begin
        state <= IDLE;
      end else if (tick) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end
    end
  end

  assign alarm     = (state == RINGING);
  assign disp_time = (set_alarm && !set_time) ? alarm_as_time : cur_time;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper with CLK_FREQ=10 and ALARM_DURATION_S=3.
// The reference model holds the time as seconds-of-day and the alarm as
// minutes-of-day and derives the expected display with division/modulo.
module tb_time_keeper;

  localparam int CF  = 10;
  localparam int DUR = 3;

  logic        clk;
  logic        reset;
  logic        set_time;
  logic        set_alarm;
  logic        alarm_en;
  logic        inc_hour;
  logic        inc_min;
  logic        alarm_off;
  logic [19:0] disp_time;
  logic        alarm;

  typedef struct {
    logic [19:0] disp;
    logic        alarm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int total;
  int bad;

  int m_secs;
  int m_alarm_min;
  int m_presc;
  int m_ring;
  int m_remain;

  time_keeper #(
    .CLK_FREQ        (CF),
    .ALARM_DURATION_S(DUR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_time (set_time),
    .set_alarm(set_alarm),
    .alarm_en (alarm_en),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .alarm_off(alarm_off),
    .disp_time(disp_time),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [19:0] exp_disp,
                             input logic exp_alarm);
    total++;
    if ((disp_time !== exp_disp) || (alarm !== exp_alarm)) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got disp_time=%05h alarm=%0b, want disp_time=%05h alarm=%0b",
               name, $time, disp_time, alarm, exp_disp, exp_alarm);
    end
  endtask

  task automatic modelReset();
    m_secs      = 0;
    m_alarm_min = 0;
    m_presc     = 0;
    m_ring      = 0;
    m_remain    = 0;
  endtask

  // Called at a falling edge: drives one cycle of inputs, advances the model
  // across the coming rising edge, queues the expectation, waits a cycle.
  task automatic applyStimulus(input logic st, input logic sa, input logic en,
                               input logic ih, input logic im, input logic off);
    int   h;
    int   m;
    logic tk;
    logic trig;
    exp_t e;
    set_time  = st;
    set_alarm = sa;
    alarm_en  = en;
    inc_hour  = ih;
    inc_min   = im;
    alarm_off = off;
    tk = !st && (m_presc == CF - 1);
    if (st || tk) m_presc = 0;
    else          m_presc = m_presc + 1;
    if (st) begin
      h = m_secs / 3600;
      m = (m_secs / 60) % 60;
      if (ih) h = (h + 1) % 24;
      if (im) m = (m + 1) % 60;
      m_secs = h * 3600 + m * 60;
    end else if (tk) begin
      m_secs = (m_secs + 1) % 86400;
    end
    if (sa && !st) begin
      h = m_alarm_min / 60;
      m = m_alarm_min % 60;
      if (ih) h = (h + 1) % 24;
      if (im) m = (m + 1) % 60;
      m_alarm_min = h * 60 + m;
    end
    trig = tk && !sa && en && (m_secs == m_alarm_min * 60);
    if (off || !en || st) begin
      m_ring = 0;
    end else if (trig) begin
      m_ring   = 1;
      m_remain = DUR;
    end else if (m_ring != 0) begin
      if (m_remain == 0) m_ring = 0;
      else if (tk)       m_remain = m_remain - 1;
    end
    if (sa && !st) e.disp = to_bcd(m_alarm_min / 60, m_alarm_min % 60, 0);
    else           e.disp = to_bcd(m_secs / 3600, (m_secs / 60) % 60, m_secs % 60);
    e.alarm = (m_ring != 0);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    set_time  = 1'b0;
    set_alarm = 1'b0;
    alarm_en  = 1'b0;
    inc_hour  = 1'b0;
    inc_min   = 1'b0;
    alarm_off = 1'b0;
    modelReset();
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulseEdits(input logic st, input logic sa, input int hours,
                            input int mins);
    for (int i = 0; i < hours; i++) begin
      applyStimulus(st, sa, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(st, sa, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < mins; i++) begin
      applyStimulus(st, sa, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(st, sa, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic runUntilSecs(input int target, input logic en, input string name);
    int n;
    n = 0;
    while ((m_secs != target) && (n < 2000)) begin
      applyStimulus(1'b0, 1'b0, en, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_secs != target) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: model never reached %0d s (at %0d s)", name, target, m_secs);
    end
  endtask

  task automatic runUntilRing(input string name);
    int n;
    n = 0;
    while ((m_ring == 0) && (n < 2000)) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_ring == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: alarm never expected to ring within budget", name);
    end
  endtask

  // Monitor: one queued expectation per rising edge, checked 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && (sb.size() > 0)) begin
        mon_e = sb.pop_front();
        checkOutput("scoreboard", mon_e.disp, mon_e.alarm);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic r_st;
    logic r_sa;
    logic r_en;
    int   n;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    set_time  = 1'b0;
    set_alarm = 1'b0;
    alarm_en  = 1'b0;
    inc_hour  = 1'b0;
    inc_min   = 1'b0;
    alarm_off = 1'b0;
    modelReset();

    // 1: reset holds everything at zero, first tick after ten clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("in reset", 20'h00000, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("first tick", 20'h00001, 1'b0);

    // 2: set 23:59, run to 23:59:59, then midnight wrap
    pulseEdits(1'b1, 1'b0, 23, 59);
    checkOutput("set 23:59", 20'h8EC80, 1'b0);
    runUntilSecs(86399, 1'b0, "to 23:59:59");
    checkOutput("23:59:59", 20'h8ECD9, 1'b0);
    runUntilSecs(0, 1'b0, "midnight");
    checkOutput("midnight wrap", 20'h00000, 1'b0);

    // 3: minute wrap without hour carry, then both pulses together
    pulseEdits(1'b1, 1'b0, 10, 59);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("10:59 +min", 20'h40000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("both pulses", 20'h44080, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: alarm at 00:02, rings for the duration then drops
    doReset();
    pulseEdits(1'b0, 1'b1, 0, 2);
    checkOutput("alarm edit view", 20'h00100, 1'b0);
    runUntilRing("alarm 00:02");
    checkOutput("alarm rises", 20'h00100, 1'b1);
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("alarm expired", 20'h00103, 1'b0);

    // 5: silence with alarm_off, no retrigger inside the same minute
    doReset();
    pulseEdits(1'b0, 1'b1, 0, 2);
    runUntilRing("alarm 00:02 again");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("alarm_off", 20'h00100, 1'b0);
    runUntilSecs(180, 1'b1, "to 00:03:00");
    checkOutput("no retrigger", 20'h00180, 1'b0);

    // alarm_off in the trigger cycle wins
    doReset();
    pulseEdits(1'b0, 1'b1, 0, 1);
    n = 0;
    while (!((m_presc == CF - 1) && (m_secs + 1 == 60)) && (n < 1000)) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("off beats trigger", 20'h00080, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset between edges while ringing
    doReset();
    pulseEdits(1'b0, 1'b1, 0, 1);
    runUntilRing("alarm 00:01");
    checkOutput("ringing before reset", 20'h00080, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset", 20'h00000, 1'b0);
    modelReset();
    sb.delete();
    set_time  = 1'b0;
    set_alarm = 1'b0;
    alarm_en  = 1'b0;
    inc_hour  = 1'b0;
    inc_min   = 1'b0;
    alarm_off = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random phase, starting armed for 00:01
    pulseEdits(1'b0, 1'b1, 0, 1);
    r_st = 1'b0;
    r_sa = 1'b0;
    r_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ((i > 700) && ($urandom_range(0, 99) == 0)) begin
        r_st = ($urandom_range(0, 3) == 0);
        r_sa = ($urandom_range(0, 2) == 0);
        r_en = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(r_st, r_sa, r_en,
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    (i > 700) && ($urandom_range(0, 29) == 0));
    end

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
